// File: rtl/seq_fixdiv_pkg.sv
// seq_fixdiv_pkg: shared FSM state type, default widths and golden divide model for seq_fixdiv
package seq_fixdiv_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} e_fixdiv_state;
  localparam int DEF_WIDTH = 24;
  localparam int DEF_FRAC_BITS = 24;
  function automatic logic [63:0] ref_div(input logic [63:0] dividend, input logic [63:0] divisor,
                                          input int frac_bits = DEF_FRAC_BITS);
    return divisor == 0 ? '1 : (dividend << frac_bits) / divisor;
  endfunction
endpackage

// File: rtl/seq_fixdiv_step.sv
// fixdiv_step: one combinational restoring-divide step (r, bit_in, d) -> (r_next, q_bit)
module fixdiv_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  logic [WIDTH:0] sh, t;
  assign sh = {r, bit_in};
  assign t = sh - {1'b0, d};
  assign q_bit = ~t[WIDTH];
  assign r_next = q_bit ? t[WIDTH-1:0] : sh[WIDTH-1:0];
endmodule

// File: rtl/seq_fixdiv.sv
// seq_fixdiv: multi-cycle restoring fixed-point divider, one quotient bit per clock
// Ports: clk, arst (async, active-high), start (level), abort, dividend/divisor (WIDTH),
//        quotient (QW), remainder (WIDTH), div_by_zero, busy (LOAD/ITER), done (DONE).
module seq_fixdiv import seq_fixdiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  localparam int QW = WIDTH + FRAC_BITS,
  localparam int CW = $clog2(QW + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [QW-1:0]    quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);
  e_fixdiv_state state, nxt;
  logic [CW-1:0] cnt;
  // partial remainder kept at WIDTH bits: it is always < d, so the shifted-out
  // extra bit lives only inside the step's WIDTH+1 bit subtraction
  logic [WIDTH-1:0] r, d, r_next;
  logic [QW-1:0] z, z_next;
  logic q_bit, last;
  fixdiv_step #(.WIDTH(WIDTH)) u_step (
    .r(r), .bit_in(z[QW-1]), .d(d), .r_next(r_next), .q_bit(q_bit)
  );
  assign z_next = {z[QW-2:0], q_bit};
  assign last = cnt == CW'(1);
  assign busy = state == LOAD || state == ITER;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? LOAD : IDLE;
      LOAD: nxt = abort ? IDLE : divisor == '0 ? DONE : ITER;
      ITER: nxt = abort ? IDLE : last ? DONE : ITER;
      DONE: nxt = start ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= IDLE;
      cnt <= '0;
      r <= '0;
      d <= '0;
      z <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= nxt;
      if (state == LOAD) begin
        d <= divisor;
        z <= QW'(dividend) << FRAC_BITS;
        r <= '0;
        cnt <= CW'(QW);
        if (!abort && divisor == '0) begin
          quotient <= '1;
          remainder <= dividend;
          div_by_zero <= 1'b1;
        end
      end
      if (state == ITER) begin
        r <= r_next;
        z <= z_next;
        cnt <= cnt - CW'(1);
        if (!abort && last) begin
          quotient <= z_next;
          remainder <= r_next;
          div_by_zero <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_seq_fixdiv.sv
// tb_seq_fixdiv: directed and random self-checking bench for seq_fixdiv
module tb_seq_fixdiv;
  import seq_fixdiv_pkg::*;
  logic clk = 0, arst = 1;
  logic start = 0, abort = 0;
  logic [23:0] dividend = 0, divisor = 0;
  logic [47:0] quotient;
  logic [23:0] remainder;
  logic div_by_zero, busy, done;
  logic s_start = 0;
  logic [7:0] s_dividend = 0, s_divisor = 0, s_quotient, s_remainder;
  logic s_dbz, s_busy, s_done;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  seq_fixdiv dut (
    .clk(clk), .arst(arst), .start(start), .abort(abort), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy), .done(done)
  );
  seq_fixdiv #(.WIDTH(8), .FRAC_BITS(0)) dut_s (
    .clk(clk), .arst(arst), .start(s_start), .abort(1'b0), .dividend(s_dividend), .divisor(s_divisor),
    .quotient(s_quotient), .remainder(s_remainder), .div_by_zero(s_dbz), .busy(s_busy), .done(s_done)
  );
  always @(negedge clk)
    if (!arst && dut.state == ITER) assert (dut.r < dut.d);
  task automatic run(input logic [23:0] a, input logic [23:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 3) begin
        dividend = ~a;
        divisor = ~b;
      end
    end while (!done && lat < 200);
  endtask
  task automatic release_start(input string name);
    @(negedge clk);
    start = 0;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) $display("FAIL %s done_drop got %b exp 0", name, done); else pass++;
  endtask
  task automatic check_res(input string name, input int lat, input int exp_lat,
                           input logic [47:0] q, input logic [23:0] rm, input logic z);
    total++;
    if (lat !== exp_lat) $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat); else pass++;
    total++;
    if (quotient !== q) $display("FAIL %s quotient got %h exp %h", name, quotient, q); else pass++;
    total++;
    if (remainder !== rm) $display("FAIL %s remainder got %h exp %h", name, remainder, rm); else pass++;
    total++;
    if (div_by_zero !== z) $display("FAIL %s div_by_zero got %b exp %b", name, div_by_zero, z); else pass++;
  endtask
  task automatic test_reset();
    #1;
    total++;
    if ({quotient, remainder, div_by_zero, busy, done} !== '0)
      $display("FAIL reset outputs got %h/%h/%b/%b/%b exp 0", quotient, remainder, div_by_zero, busy, done);
    else pass++;
    @(negedge clk);
    arst = 0;
  endtask
  task automatic test_divide();
    int lat;
    run(24'd3, 24'd2, lat);
    check_res("3/2", lat, 50, 48'h000001800000, 24'd0, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b1) $display("FAIL hold_done got %b exp 1", done); else pass++;
    release_start("3/2");
    run(24'd1, 24'd3, lat);
    check_res("1/3", lat, 50, 48'h000000555555, 24'd1, 1'b0);
    release_start("1/3");
    run(24'hFFFFFF, 24'd1, lat);
    check_res("max/1", lat, 50, 48'hFFFFFF000000, 24'd0, 1'b0);
    release_start("max/1");
    run(24'd5, 24'd0, lat);
    check_res("5/0", lat, 2, 48'hFFFFFFFFFFFF, 24'd5, 1'b1);
    release_start("5/0");
  endtask
  task automatic test_abort();
    int lat;
    logic seen = 0;
    @(negedge clk);
    dividend = 24'd100;
    divisor = 24'd7;
    start = 1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    abort = 1;
    start = 0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle busy got %b done got %b exp 0/0", busy, done);
    else pass++;
    abort = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      seen |= done;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL abort_no_done got %b exp 0", seen); else pass++;
    check_res("abort_keep", 2, 2, 48'hFFFFFFFFFFFF, 24'd5, 1'b1);
    run(24'd100, 24'd7, lat);
    check_res("100/7", lat, 50, 48'h00000E492492, 24'd2, 1'b0);
    release_start("100/7");
  endtask
  task automatic test_relaunch();
    int lat = 0;
    @(negedge clk);
    dividend = 24'd3;
    divisor = 24'd2;
    start = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL relaunch_idle busy got %b exp 0", busy); else pass++;
    abort = 0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) $display("FAIL relaunch_load busy got %b exp 1", busy); else pass++;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_res("relaunch", lat, 49, 48'h000001800000, 24'd0, 1'b0);
    release_start("relaunch");
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] a, b, eq, er;
      int lat = 0;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      eq = 8'(ref_div(64'(a), 64'(b), 0));
      er = b == 0 ? a : a % b;
      @(negedge clk);
      s_dividend = a;
      s_divisor = b;
      s_start = 1;
      do begin
        @(posedge clk);
        #1;
        lat++;
        if (lat == 3) s_dividend = ~a;
      end while (!s_done && lat < 100);
      total++;
      if (lat !== (b == 0 ? 2 : 10)) $display("FAIL rnd_lat %0d/%0d got %0d exp %0d", a, b, lat, b == 0 ? 2 : 10);
      else pass++;
      total++;
      if (s_quotient !== eq || s_remainder !== er || s_dbz !== (b == 0))
        $display("FAIL rnd %0d/%0d got q=%0d r=%0d z=%b exp q=%0d r=%0d z=%b", a, b, s_quotient, s_remainder, s_dbz,
                 eq, er, b == 0);
      else pass++;
      @(negedge clk);
      s_start = 0;
      @(posedge clk);
      #1;
      total++;
      if (s_done !== 1'b0) $display("FAIL rnd_drop got %b exp 0", s_done); else pass++;
    end
  endtask
  task automatic test_mid_reset();
    @(negedge clk);
    dividend = 24'd9;
    divisor = 24'd4;
    start = 1;
    repeat (6) @(posedge clk);
    #2;
    arst = 1;
    #1;
    total++;
    if ({quotient, remainder, div_by_zero, busy, done} !== '0)
      $display("FAIL mid_reset got %h/%h/%b/%b/%b exp 0", quotient, remainder, div_by_zero, busy, done);
    else pass++;
    start = 0;
    @(negedge clk);
    arst = 0;
  endtask
  initial begin
    test_reset();
    test_divide();
    test_abort();
    test_relaunch();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
